// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: trap cause codes, reset PC and trap vector,
// plus the next-PC target helper used by the PC/trap datapath.
package cpu_pkg;

   localparam logic [31:0] CAUSE_ILLEGAL       = 32'h1;
   localparam logic [31:0] CAUSE_OVERFLOW      = 32'h2;
   localparam logic [31:0] CAUSE_MISALIGN      = 32'h3;
   localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h300;
   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0;

   // JALR targets drop bit 0 of the computed address before the alignment check.
   function automatic logic [31:0] next_pc_target(input logic [31:0] alu_result,
                                                  input logic        is_jalr);
      logic [31:0] t;
      t = alu_result;
      if (is_jalr) t[0] = 1'b0;
      return t;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with asynchronous clear; SATURATE selects holding at all-ones
// instead of wrapping modulo 2^W.
module sat_counter #(
   parameter int W        = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc) begin
         if (!(SATURATE && (&count))) count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pc_trap_unit.sv
// PC, OldPC, EPC and cause ownership for the multi-cycle CPU, with sticky halt,
// misaligned-target rejection and retire/trap debug counters.
module pc_trap_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic             ir_write,
   input  logic             is_jalr,
   input  logic             trap,
   input  logic             cause_write,
   input  logic [31:0]      cause_code,
   input  logic             halt,
   input  logic [31:0]      alu_result,
   output logic [31:0]      pc,
   output logic [31:0]      old_pc,
   output logic [31:0]      epc,
   output logic [31:0]      cause,
   output logic             halted,
   output logic             misalign,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] trap_cnt
);

   logic [31:0] target;
   logic        target_ok;
   logic        active;
   logic        misalign_req;
   logic        retire_inc;
   logic        trap_inc;

   // NOTE: every always_comb output is assigned before any condition, so no latch can form.
   always_comb begin
      target       = next_pc_target(alu_result, is_jalr);
      target_ok    = (target[1:0] == 2'b00);
      // A halt strobe freezes its own cycle as well as every later one.
      active       = !halted && !halt;
      misalign_req = active && pc_write && !trap && !target_ok;
      retire_inc   = active && ir_write;
      trap_inc     = active && trap;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         old_pc   <= '0;
         epc      <= '0;
         cause    <= '0;
         halted   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         misalign <= misalign_req;
         if (halt) halted <= 1'b1;
         if (active) begin
            if (ir_write) old_pc <= pc;
            if (trap) begin
               pc  <= TRAP_VECTOR;
               epc <= old_pc;
            end else if (pc_write && target_ok) begin
               pc <= target;
            end
            // An explicit cause write wins over the misaligned-target cause.
            if (cause_write)       cause <= cause_code;
            else if (misalign_req) cause <= CAUSE_MISALIGN;
         end
      end
   end

   sat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_retire_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (retire_inc),
      .count (retire_cnt)
   );

   sat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_trap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (trap_inc),
      .count (trap_cnt)
   );

endmodule
